pll_lock_seq: RTL

- Parametrised PLL lock and reset sequencer. It generalises the fixed-count PLL simulation model into a block that drives the PLL reset, qualifies the raw PLL lock, retries on timeout, and releases CH_NUM downstream reset domains in a staggered order.
- Sits between the PLL primitive (or its sim model) and the camera/interface logic.
- Also handles lock loss, bounded retry, and a sticky failure state.

---
 rtl/pll_lock_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_seq.sv
// PLL lock and reset sequencer: drives the PLL reset, qualifies raw lock with bounded
// retry and a sticky failure state, then releases CH_NUM reset domains in a staggered order.
module pll_lock_seq #(
  parameter int unsigned CH_NUM      = 2,
  parameter int unsigned CW          = 16,
  parameter int unsigned HOLD_CYC    = 5,
  parameter int unsigned STABLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned STAGGER     = 4,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              restart,
  input  logic              pll_lock_in,
  output logic              pll_rst,
  output logic              lock,
  output logic [CH_NUM-1:0] rst_n_out,
  output logic              fail,
  output logic [3:0]        retry_cnt,
  output logic [2:0]        state
);

  localparam int unsigned SW = 3;
  localparam int unsigned RW = 4;

  typedef enum logic [SW-1:0] {
    S_IDLE   = 3'd0,
    S_HOLD   = 3'd1,
    S_WAIT   = 3'd2,
    S_LOCKED = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [CW-1:0]     r_hold_cnt;
  logic [CW-1:0]     r_stable_cnt;
  logic [CW-1:0]     r_timeout_cnt;
  logic [CW-1:0]     r_stag_cnt;
  logic [RW-1:0]     r_retry;
  logic [RW-1:0]     w_retry_nxt;
  logic              r_pll_rst;
  logic              r_lock;
  logic              r_fail;
  logic [CH_NUM-1:0] r_rst_n;
  logic [CH_NUM-1:0] w_rel;
  logic              w_hold_done;
  logic              w_stable_done;
  logic              w_timeout;
  logic              w_stag_sat;
  logic              w_stay_hold;
  logic              w_stay_wait;
  logic              w_stay_locked;

  // Counter terminal conditions and per-channel release strobes
  always_comb begin
    w_hold_done   = (r_hold_cnt == CW'(HOLD_CYC - 1));
    w_stable_done = pll_lock_in && (r_stable_cnt == CW'(STABLE_CYC - 1));
    w_timeout     = (r_timeout_cnt == CW'(TIMEOUT_CYC - 1));
    w_stag_sat    = (r_stag_cnt == CW'(STAGGER * CH_NUM));
    w_rel         = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      w_rel[i] = (r_stag_cnt == CW'(STAGGER * (i + 1) - 1));
    end
  end

  // Next state and retry count; en=0 overrides everything, lock beats a same-cycle timeout
  always_comb begin
    w_nxt       = r_state;
    w_retry_nxt = r_retry;
    if (!en) begin
      w_nxt       = S_IDLE;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: w_nxt = S_HOLD;
        S_HOLD: begin
          if (w_hold_done) w_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (w_stable_done) begin
            w_nxt       = S_LOCKED;
            w_retry_nxt = '0;
          end else if (w_timeout) begin
            if (r_retry == RW'(MAX_RETRY)) begin
              w_nxt = S_FAIL;
            end else begin
              w_nxt       = S_HOLD;
              w_retry_nxt = r_retry + RW'(1);
            end
          end
        end
        S_LOCKED: begin
          if (!pll_lock_in) w_nxt = S_HOLD;
        end
        S_FAIL: begin
          if (restart) begin
            w_nxt       = S_HOLD;
            w_retry_nxt = '0;
          end
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // A counter only advances while its state is kept; any entry starts it from zero
  always_comb begin
    w_stay_hold   = (r_state == S_HOLD)   && (w_nxt == S_HOLD);
    w_stay_wait   = (r_state == S_WAIT)   && (w_nxt == S_WAIT);
    w_stay_locked = (r_state == S_LOCKED) && (w_nxt == S_LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_pll_rst     <= 1'b1;
      r_lock        <= 1'b0;
      r_fail        <= 1'b0;
      r_retry       <= '0;
      r_rst_n       <= '0;
      r_hold_cnt    <= '0;
      r_stable_cnt  <= '0;
      r_timeout_cnt <= '0;
      r_stag_cnt    <= '0;
    end else begin
      r_state   <= w_nxt;
      r_pll_rst <= (w_nxt == S_IDLE) || (w_nxt == S_HOLD) || (w_nxt == S_FAIL);
      r_lock    <= (w_nxt == S_LOCKED);
      r_fail    <= (w_nxt == S_FAIL);
      r_retry   <= w_retry_nxt;

      r_hold_cnt <= w_stay_hold ? (r_hold_cnt + CW'(1)) : '0;

      if (w_stay_wait) begin
        r_stable_cnt  <= pll_lock_in ? (r_stable_cnt + CW'(1)) : '0;
        r_timeout_cnt <= r_timeout_cnt + CW'(1);
      end else begin
        r_stable_cnt  <= '0;
        r_timeout_cnt <= '0;
      end

      // Channels release one by one and stay released until LOCKED is left
      if (w_stay_locked) begin
        r_stag_cnt <= w_stag_sat ? r_stag_cnt : (r_stag_cnt + CW'(1));
        r_rst_n    <= r_rst_n | w_rel;
      end else begin
        r_stag_cnt <= '0;
        r_rst_n    <= '0;
      end
    end
  end

  assign pll_rst   = r_pll_rst;
  assign lock      = r_lock;
  assign rst_n_out = r_rst_n;
  assign fail      = r_fail;
  assign retry_cnt = r_retry;
  assign state     = r_state;

endmodule
